// File: rtl/flr_pkg.sv
// Shared types and sizing helpers for the FLR sequencer.
package flr_pkg;

  localparam int unsigned NUM_PF_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } flr_state_e;

  // Counter wide enough for the larger of the two phase lengths, plus one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  // Index width for a vector of n functions (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flr_rr_arbiter.sv
// Combinational round-robin pick: first pending function at or after rr_ptr, wrapping.
module flr_rr_arbiter
  import flr_pkg::*;
#(
  parameter  int unsigned NUM_PF = 4,
  localparam int unsigned PW     = idx_width(NUM_PF)
) (
  input  logic [NUM_PF-1:0] pending,
  input  logic [PW-1:0]     rr_ptr,
  output logic [PW-1:0]     grant_idx,
  output logic              grant_valid
);

  logic [PW-1:0] probe;

  // Scan NUM_PF positions starting at rr_ptr; the first hit wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    probe       = '0;
    for (int unsigned i = 0; i < NUM_PF; i++) begin
      probe = PW'((32'(rr_ptr) + i) % NUM_PF);
      if (!grant_valid && pending[probe]) begin
        grant_valid = 1'b1;
        grant_idx   = probe;
      end
    end
  end

endmodule

// File: rtl/flr_sequencer.sv
// Per-function FLR responder: edge-detects FLR requests, holds the function in reset,
// waits for quiesce (bounded by a drain timeout) and returns a one-cycle done.
module flr_sequencer
  import flr_pkg::*;
#(
  parameter  int unsigned NUM_PF        = 4,
  parameter  int unsigned RESET_CYCLES  = 16,
  parameter  int unsigned DRAIN_TIMEOUT = 1024,
  localparam int unsigned PW            = idx_width(NUM_PF),
  localparam int unsigned CW            = cnt_width(RESET_CYCLES, DRAIN_TIMEOUT)
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  input  logic [NUM_PF-1:0] cfg_flr_in_process,
  input  logic [NUM_PF-1:0] func_quiesced,
  output logic [NUM_PF-1:0] cfg_flr_done,
  output logic [NUM_PF-1:0] func_reset_req,
  output logic              flr_busy,
  output logic [NUM_PF-1:0] flr_timeout
);

  flr_state_e        state_q, state_d;
  logic [NUM_PF-1:0] prev_q;
  logic              prev_vld_q;
  logic [NUM_PF-1:0] pending_q;
  logic [NUM_PF-1:0] pend_clr;
  logic [NUM_PF-1:0] rise;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     cur_q, cur_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_PF-1:0] req_d, done_d, tmo_d;
  logic [PW-1:0]     grant_idx;
  logic              grant_valid;

  // prev is only trusted after one post-reset sample, so a level already high at
  // reset release is not mistaken for a new FLR.
  assign rise = cfg_flr_in_process & ~prev_q & {NUM_PF{prev_vld_q}};

  flr_rr_arbiter #(.NUM_PF(NUM_PF)) u_arb (
    .pending     (pending_q),
    .rr_ptr      (rr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Next-state, counter and registered-output values.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    pend_clr = '0;
    req_d    = func_reset_req;
    done_d   = '0;
    tmo_d    = flr_timeout;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d             = ST_RESET;
          cur_d               = grant_idx;
          pend_clr[grant_idx] = 1'b1;
          rr_d                = (grant_idx == PW'(NUM_PF - 1)) ? '0 : grant_idx + 1'b1;
          req_d               = '0;
          req_d[grant_idx]    = 1'b1;
          cnt_d               = '0;
        end
      end
      ST_RESET: begin
        if (!cfg_flr_in_process[cur_q]) begin
          state_d = ST_IDLE;
          req_d   = '0;
        end else if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The forced ack is taken once the counter has passed DRAIN_TIMEOUT-1, which
        // puts it 3+RESET_CYCLES+DRAIN_TIMEOUT cycles after the request.
        if (!cfg_flr_in_process[cur_q]) begin
          state_d = ST_IDLE;
          req_d   = '0;
        end else if (func_quiesced[cur_q]) begin
          state_d       = ST_DONE;
          req_d         = '0;
          done_d[cur_q] = 1'b1;
          tmo_d[cur_q]  = 1'b0;
        end else if (cnt_q == CW'(DRAIN_TIMEOUT)) begin
          state_d       = ST_DONE;
          req_d         = '0;
          done_d[cur_q] = 1'b1;
          tmo_d[cur_q]  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q        <= ST_IDLE;
      prev_q         <= '0;
      prev_vld_q     <= 1'b0;
      pending_q      <= '0;
      rr_q           <= '0;
      cur_q          <= '0;
      cnt_q          <= '0;
      func_reset_req <= '0;
      cfg_flr_done   <= '0;
      flr_timeout    <= '0;
      flr_busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= cfg_flr_in_process;
      prev_vld_q     <= 1'b1;
      pending_q      <= (pending_q & ~pend_clr) | rise;
      rr_q           <= rr_d;
      cur_q          <= cur_d;
      cnt_q          <= cnt_d;
      func_reset_req <= req_d;
      cfg_flr_done   <= done_d;
      flr_timeout    <= tmo_d;
      flr_busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_flr_sequencer.sv
// Scoreboard bench for flr_sequencer with default parameters.
module tb_flr_sequencer;

  localparam int NPF = 4;

  logic           user_clk = 1'b0;
  logic           user_reset_n = 1'b0;
  logic [NPF-1:0] cfg_flr_in_process = '0;
  logic [NPF-1:0] func_quiesced = '1;
  logic [NPF-1:0] cfg_flr_done;
  logic [NPF-1:0] func_reset_req;
  logic           flr_busy;
  logic [NPF-1:0] flr_timeout;

  typedef struct {
    int fn;
    int cyc;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  flr_sequencer #(
    .NUM_PF        (4),
    .RESET_CYCLES  (16),
    .DRAIN_TIMEOUT (1024)
  ) dut (
    .user_clk           (user_clk),
    .user_reset_n       (user_reset_n),
    .cfg_flr_in_process (cfg_flr_in_process),
    .func_quiesced      (func_quiesced),
    .cfg_flr_done       (cfg_flr_done),
    .func_reset_req     (func_reset_req),
    .flr_busy           (flr_busy),
    .flr_timeout        (flr_timeout)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int fn, input int c, input bit tmo);
    exp_t e;
    e.fn = fn; e.cyc = c; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  // Advance to 1 time unit after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    goto(cyc + n);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge user_clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("wait_done_budget", exp_q.size(), 0);
  endtask

  // Output monitor: one-hot request, and every done pulse matched against the scoreboard.
  always @(negedge user_clk) begin
    exp_t        e;
    logic [3:0]  t;
    if (user_reset_n) begin
      check("req_onehot0", 32'($onehot0(func_reset_req)), 1);
      if (cfg_flr_done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", cfg_flr_done, 0);
        end else begin
          e = exp_q.pop_front();
          t = flr_timeout >> e.fn;
          check("done_vec", cfg_flr_done, 32'(1) << e.fn);
          check("done_cycle", cyc, e.cyc);
          check("done_timeout_flag", t[0], e.tmo);
          check("done_busy", flr_busy, 1);
          check("done_req_low", func_reset_req, 0);
        end
      end
    end
  end

  initial begin
    int c0;
    #22 user_reset_n = 1'b1;
    goto(4);
    check("rst_req", func_reset_req, 0);
    check("rst_done", cfg_flr_done, 0);
    check("rst_busy", flr_busy, 0);
    check("rst_timeout", flr_timeout, 0);

    // Simultaneous FLRs on all functions, round-robin from 0.
    c0 = cyc;
    cfg_flr_in_process = 4'b1111;
    for (int i = 0; i < 4; i++) push(i, c0 + 19 + 19 * i, 1'b0);
    goto(c0 + 2);
    check("sim_req0", func_reset_req, 4'b0001);
    goto(c0 + 21);
    check("sim_req1", func_reset_req, 4'b0010);
    wait_empty(200);
    cfg_flr_in_process = '0;
    step(3);

    // Single FLR on function 2, already quiesced.
    c0 = cyc;
    cfg_flr_in_process = 4'b0100;
    push(2, c0 + 19, 1'b0);
    goto(c0 + 1);
    check("single_req_c1", func_reset_req, 0);
    goto(c0 + 2);
    check("single_req_c2", func_reset_req, 4'b0100);
    check("single_busy", flr_busy, 1);
    goto(c0 + 18);
    check("single_req_c18", func_reset_req, 4'b0100);
    goto(c0 + 19);
    check("single_req_c19", func_reset_req, 0);
    wait_empty(50);
    goto(c0 + 21);
    check("single_idle", flr_busy, 0);
    cfg_flr_in_process = '0;
    step(3);

    // Slow drain on function 0.
    c0 = cyc;
    func_quiesced = 4'b1110;
    cfg_flr_in_process = 4'b0001;
    push(0, c0 + 101, 1'b0);
    goto(c0 + 100);
    check("slow_req_held", func_reset_req, 4'b0001);
    func_quiesced = '1;
    wait_empty(50);
    cfg_flr_in_process = '0;
    step(3);

    // Drain timeout on function 1, then a clean FLR clears the flag.
    c0 = cyc;
    func_quiesced = 4'b1101;
    cfg_flr_in_process = 4'b0010;
    push(1, c0 + 1043, 1'b1);
    wait_empty(1100);
    step(1);
    check("tmo_sticky", flr_timeout, 4'b0010);
    cfg_flr_in_process = '0;
    func_quiesced = '1;
    step(1);
    c0 = cyc;
    cfg_flr_in_process = 4'b0010;
    push(1, c0 + 19, 1'b0);
    wait_empty(50);
    step(1);
    check("tmo_cleared", flr_timeout, 0);
    cfg_flr_in_process = '0;
    step(3);

    // Abort in the 5th DRAIN cycle of function 2.
    c0 = cyc;
    func_quiesced = 4'b1011;
    cfg_flr_in_process = 4'b0100;
    goto(c0 + 22);
    check("abort_req_before", func_reset_req, 4'b0100);
    cfg_flr_in_process = '0;
    goto(c0 + 23);
    check("abort_req_after", func_reset_req, 0);
    check("abort_busy", flr_busy, 0);
    step(10);
    check("abort_timeout", flr_timeout, 0);
    check("abort_still_idle", flr_busy, 0);
    func_quiesced = '1;

    // Asynchronous reset mid-DRAIN; held-high request must not retrigger.
    c0 = cyc;
    func_quiesced = 4'b0111;
    cfg_flr_in_process = 4'b1000;
    goto(c0 + 25);
    check("arst_busy_before", flr_busy, 1);
    #2 user_reset_n = 1'b0;
    #1;
    check("arst_req", func_reset_req, 0);
    check("arst_done", cfg_flr_done, 0);
    check("arst_busy", flr_busy, 0);
    check("arst_timeout", flr_timeout, 0);
    step(2);
    user_reset_n = 1'b1;
    step(40);
    check("arst_no_retrigger_busy", flr_busy, 0);
    check("arst_no_retrigger_req", func_reset_req, 0);
    check("sb_empty", exp_q.size(), 0);
    cfg_flr_in_process = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
